// File: rtl/route_pkg.sv
// Shared types and default sizes for the routing memory and its scheduler.
package route_pkg;
  localparam int DEPTH      = 32;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_WIDTH  = 9;

  typedef enum logic [2:0] {IDLE, CHECK, ROUTE, HOLD, GAP} route_state_t;
endpackage

// File: rtl/route_scheduler_if.sv
// Host, job, memory_top and PE-stream signals of the route scheduler.
interface route_scheduler_if #(
  parameter int Depth      = route_pkg::DEPTH,
  parameter int DataWidth  = route_pkg::DATA_WIDTH,
  parameter int MaxWidth   = route_pkg::MAX_WIDTH,
  parameter int CountWidth = 8,
  parameter int AddrWidth  = $clog2(Depth),
  parameter int LenWidth   = $clog2(MaxWidth + 1)
);
  logic                          hostWriteEn;
  logic [AddrWidth-1:0]          hostWriteAddr;
  logic [DataWidth-1:0]          hostDataIn;
  logic                          hostWriteErr;
  logic                          jobValid;
  logic                          jobReady;
  logic [AddrWidth-1:0]          jobBase;
  logic [AddrWidth-1:0]          jobStride;
  logic [LenWidth-1:0]           jobLen;
  logic [CountWidth-1:0]         jobCount;
  logic                          jobErr;
  logic                          memWriteEn;
  logic [AddrWidth-1:0]          memWriteAddr;
  logic [DataWidth-1:0]          memDataIn;
  logic                          memRouteEn;
  logic [AddrWidth-1:0]          memStartAddr;
  logic [AddrWidth-1:0]          memFinalAddr;
  logic                          memFinished;
  logic [MaxWidth*DataWidth-1:0] memDataOut;
  logic                          outValid;
  logic                          outReady;
  logic [MaxWidth*DataWidth-1:0] outData;
  logic [CountWidth-1:0]         outIndex;
  logic                          outLast;
  logic                          busy;
  logic                          done;

  modport master (
    input  hostWriteEn, hostWriteAddr, hostDataIn, jobValid, jobBase, jobStride,
           jobLen, jobCount, memFinished, memDataOut, outReady,
    output hostWriteErr, jobReady, jobErr, memWriteEn, memWriteAddr, memDataIn,
           memRouteEn, memStartAddr, memFinalAddr, outValid, outData, outIndex,
           outLast, busy, done
  );

  modport slave (
    output hostWriteEn, hostWriteAddr, hostDataIn, jobValid, jobBase, jobStride,
           jobLen, jobCount, memFinished, memDataOut, outReady,
    input  hostWriteErr, jobReady, jobErr, memWriteEn, memWriteAddr, memDataIn,
           memRouteEn, memStartAddr, memFinalAddr, outValid, outData, outIndex,
           outLast, busy, done
  );
endinterface

// File: rtl/route_addr_gen.sv
// Window address generator: running start address instead of base + k*stride.
module route_addr_gen #(
  parameter int AddrWidth  = 5,
  parameter int LenWidth   = 4,
  parameter int CountWidth = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  advance,
  input  logic [AddrWidth-1:0]  baseIn,
  input  logic [AddrWidth-1:0]  strideIn,
  input  logic [LenWidth-1:0]   len,
  input  logic [CountWidth-1:0] count,
  output logic [AddrWidth-1:0]  startAddr,
  output logic [AddrWidth-1:0]  finalAddr,
  output logic [AddrWidth-1:0]  stride,
  output logic [CountWidth-1:0] k,
  output logic                  isLast
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      startAddr <= '0;
      stride    <= '0;
      k         <= '0;
    end else if (load) begin
      startAddr <= baseIn;
      stride    <= strideIn;
      k         <= '0;
    end else if (advance) begin
      startAddr <= startAddr + stride;
      k         <= k + CountWidth'(1);
    end
  end

  // Exclusive end; legal jobs never exceed Depth, so only Depth itself can wrap.
  assign finalAddr = startAddr + AddrWidth'(len);
  assign isLast    = (k == count - CountWidth'(1));
endmodule

// File: rtl/route_scheduler.sv
// Job-level controller: checks a strided window job, routes each window, streams results.
module route_scheduler
  import route_pkg::*;
#(
  parameter int Depth      = DEPTH,
  parameter int DataWidth  = DATA_WIDTH,
  parameter int MaxWidth   = MAX_WIDTH,
  parameter int CountWidth = 8,
  parameter int AddrWidth  = $clog2(Depth),
  parameter int LenWidth   = $clog2(MaxWidth + 1)
) (
  input logic                clk,
  input logic                rst,
  route_scheduler_if.master  bus
);
  localparam int BoundWidth = AddrWidth + CountWidth + LenWidth + 1;

  route_state_t                  state;
  logic [LenWidth-1:0]           len;
  logic [CountWidth-1:0]         count;
  logic [CountWidth-1:0]         countM1;
  logic [AddrWidth-1:0]          startAddr;
  logic [AddrWidth-1:0]          finalAddr;
  logic [AddrWidth-1:0]          stride;
  logic [CountWidth-1:0]         k;
  logic                          isLast;
  logic                          load;
  logic                          advance;
  logic                          lenBad;
  logic                          boundBad;
  logic                          countZero;
  logic [BoundWidth-1:0]         bound;
  logic [MaxWidth*DataWidth-1:0] maskedData;

  assign load    = (state == IDLE) & bus.jobValid & bus.jobReady;
  assign advance = (state == HOLD) & bus.outReady & ~bus.outLast;

  route_addr_gen #(
    .AddrWidth (AddrWidth),
    .LenWidth  (LenWidth),
    .CountWidth(CountWidth)
  ) uAddrGen (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .advance  (advance),
    .baseIn   (bus.jobBase),
    .strideIn (bus.jobStride),
    .len      (len),
    .count    (count),
    .startAddr(startAddr),
    .finalAddr(finalAddr),
    .stride   (stride),
    .k        (k),
    .isLast   (isLast)
  );

  // In CHECK the running start address still equals the job base.
  assign countZero = (count == '0);
  assign countM1   = count - CountWidth'(1);
  assign bound     = BoundWidth'(startAddr) + BoundWidth'(countM1) * BoundWidth'(stride)
                   + BoundWidth'(len);
  assign lenBad    = (len == '0) || (len > LenWidth'(MaxWidth));
  assign boundBad  = !countZero && (bound > BoundWidth'(Depth));

  for (genvar e = 0; e < MaxWidth; e++) begin : gLane
    assign maskedData[e*DataWidth +: DataWidth] =
      (LenWidth'(e) < len) ? bus.memDataOut[e*DataWidth +: DataWidth] : '0;
  end

  assign bus.memWriteEn   = bus.hostWriteEn & (state == IDLE);
  assign bus.memWriteAddr = bus.hostWriteAddr;
  assign bus.memDataIn    = bus.hostDataIn;
  assign bus.memStartAddr = startAddr;
  assign bus.memFinalAddr = finalAddr;
  assign bus.busy         = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      len              <= '0;
      count            <= '0;
      bus.jobReady     <= 1'b1;
      bus.jobErr       <= 1'b0;
      bus.done         <= 1'b0;
      bus.hostWriteErr <= 1'b0;
      bus.memRouteEn   <= 1'b0;
      bus.outValid     <= 1'b0;
      bus.outData      <= '0;
      bus.outIndex     <= '0;
      bus.outLast      <= 1'b0;
    end else begin
      bus.jobErr       <= 1'b0;
      bus.done         <= 1'b0;
      bus.hostWriteErr <= bus.hostWriteEn & (state != IDLE);
      unique case (state)
        IDLE: if (load) begin
          len          <= bus.jobLen;
          count        <= bus.jobCount;
          bus.jobReady <= 1'b0;
          state        <= CHECK;
        end
        CHECK: begin
          if (lenBad || boundBad) begin
            bus.jobErr   <= 1'b1;
            bus.jobReady <= 1'b1;
            state        <= IDLE;
          end else if (countZero) begin
            bus.done     <= 1'b1;
            bus.jobReady <= 1'b1;
            state        <= IDLE;
          end else begin
            bus.memRouteEn <= 1'b1;
            state          <= ROUTE;
          end
        end
        ROUTE: if (bus.memFinished) begin
          bus.outData    <= maskedData;
          bus.outIndex   <= k;
          bus.outLast    <= isLast;
          bus.memRouteEn <= 1'b0;
          bus.outValid   <= 1'b1;
          state          <= HOLD;
        end
        HOLD: if (bus.outReady) begin
          bus.outValid <= 1'b0;
          if (bus.outLast) begin
            bus.done     <= 1'b1;
            bus.jobReady <= 1'b1;
            state        <= IDLE;
          end else begin
            state <= GAP;
          end
        end
        // Router needs routeEn low for a cycle before it accepts the next window.
        GAP: begin
          bus.memRouteEn <= 1'b1;
          state          <= ROUTE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_route_scheduler.sv
// Directed bench for route_scheduler with a behavioural memory_top router model.
module tb_route_scheduler;
  import route_pkg::*;

  localparam int Depth      = 32;
  localparam int DataWidth  = 8;
  localparam int MaxWidth   = 9;
  localparam int CountWidth = 8;
  localparam int AddrWidth  = $clog2(Depth);
  localparam int LenWidth   = $clog2(MaxWidth + 1);
  localparam int VecW       = MaxWidth * DataWidth;

  typedef struct {
    int base;
    int stride;
    int len;
    int count;
    bit expErr;
    int delay;
  } jobVec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  route_scheduler_if #(.Depth(Depth), .DataWidth(DataWidth), .MaxWidth(MaxWidth),
                       .CountWidth(CountWidth)) bus ();

  route_scheduler #(.Depth(Depth), .DataWidth(DataWidth), .MaxWidth(MaxWidth),
                    .CountWidth(CountWidth)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Router model: finishes routeEn-high windows after routerLat cycles.
  logic [DataWidth-1:0] buffer [Depth];
  int routerLat = 3;
  int rcnt;

  always @(posedge clk) if (bus.memWriteEn) buffer[bus.memWriteAddr] <= bus.memDataIn;

  always @(posedge clk or negedge rst) begin
    if (!rst) rcnt <= 0;
    else if (!bus.memRouteEn) rcnt <= 0;
    else if (rcnt < routerLat) rcnt <= rcnt + 1;
  end

  assign bus.memFinished = bus.memRouteEn && (rcnt == routerLat);

  always_comb begin
    bus.memDataOut = '0;
    for (int e = 0; e < MaxWidth; e++)
      bus.memDataOut[e*DataWidth +: DataWidth] = buffer[(int'(bus.memStartAddr) + e) % Depth];
  end

  int checks = 0;
  int errors = 0;
  logic [VecW-1:0] lastData;
  jobVec_t vecs [9];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Buffer holds value == address, so element e of a window is start+e.
  function automatic logic [VecW-1:0] expVec(input int start, input int len);
    logic [VecW-1:0] v = '0;
    for (int e = 0; e < MaxWidth; e++)
      if (e < len) v[e*DataWidth +: DataWidth] = DataWidth'((start + e) % Depth);
    return v;
  endfunction

  // Returns at the negedge of cycle 1 (acceptance edge is edge 0).
  task automatic sendJob(input int base, input int stride, input int len, input int count);
    int t = 0;
    @(negedge clk);
    while (!bus.jobReady && t < 100) begin @(negedge clk); t++; end
    chk("jobReady before accept", bus.jobReady, 1);
    bus.jobBase   = AddrWidth'(base);
    bus.jobStride = AddrWidth'(stride);
    bus.jobLen    = LenWidth'(len);
    bus.jobCount  = CountWidth'(count);
    bus.jobValid  = 1'b1;
    @(negedge clk);
    bus.jobValid  = 1'b0;
  endtask

  task automatic waitRoute(output bit ok);
    ok = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.memRouteEn) begin ok = 1; break; end
    end
  endtask

  task automatic runJob(input jobVec_t v);
    int cyc = 1, win = 0, hold = 0, sinceHs = -1, st;
    bit fin = 0, routeChecked = 0, hsPending = 0;
    logic [VecW-1:0] held = '0;
    sendJob(v.base, v.stride, v.len, v.count);
    chk("busy in CHECK", bus.busy, 1);
    chk("no route in CHECK", bus.memRouteEn, 0);
    while (!fin && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (hsPending) begin
        hsPending    = 0;
        bus.outReady = 1'b0;
        chk("outValid drops after handshake", bus.outValid, 0);
        chk("route idle in GAP", bus.memRouteEn, 0);
        win++; hold = 0; routeChecked = 0; sinceHs = 1;
        if (win == v.count) begin
          chk("done after last handshake", bus.done, 1);
          chk("jobReady with done", bus.jobReady, 1);
          fin = 1;
        end
        continue;
      end
      if (sinceHs == 1) begin
        chk("route 2 cycles after handshake", bus.memRouteEn, 1);
        sinceHs = -1;
      end
      if (v.expErr || v.count == 0) begin
        chk("no route activity", bus.memRouteEn, 0);
        if (cyc == 2) begin
          chk("jobErr pulse", bus.jobErr, v.expErr);
          chk("done for empty job", bus.done, !v.expErr);
          chk("no output for no-window job", bus.outValid, 0);
          fin = 1;
        end
        continue;
      end
      if (cyc == 2) begin
        chk("first route at cycle 2", bus.memRouteEn, 1);
        chk("no jobErr on legal job", bus.jobErr, 0);
      end
      if (bus.memRouteEn && !routeChecked) begin
        st = (v.base + win * v.stride) % Depth;
        chk("memStartAddr", bus.memStartAddr, st);
        chk("memFinalAddr", bus.memFinalAddr, (st + v.len) % Depth);
        routeChecked = 1;
      end
      if (bus.outValid) begin
        chk("route off while holding", bus.memRouteEn, 0);
        if (hold == 0) begin
          st = (v.base + win * v.stride) % Depth;
          chk("outData", bus.outData, expVec(st, v.len));
          chk("outIndex", bus.outIndex, win);
          chk("outLast", bus.outLast, win == v.count - 1);
          held     = bus.outData;
          lastData = bus.outData;
        end else begin
          chk("outData stable under backpressure", bus.outData, held);
        end
        if (hold >= ((win == 0) ? v.delay : 0)) begin
          bus.outReady = 1'b1;
          hsPending    = 1;
        end
        hold++;
      end
    end
    if (!fin) chk("job finished within budget", 0, 1);
    bus.outReady = 1'b0;
    @(negedge clk);
    chk("done/jobErr single pulse", {bus.done, bus.jobErr}, 0);
  endtask

  initial begin
    bit ok;
    vecs[0] = '{0, 0, 9, 1, 0, 0};
    vecs[1] = '{2, 4, 3, 4, 0, 0};
    vecs[2] = '{1, 3, 5, 3, 0, 5};
    vecs[3] = '{0, 0, 0, 1, 1, 0};
    vecs[4] = '{0, 0, 10, 1, 1, 0};
    vecs[5] = '{30, 0, 3, 1, 1, 0};
    vecs[6] = '{20, 5, 3, 3, 1, 0};
    vecs[7] = '{0, 1, 4, 0, 0, 0};
    vecs[8] = '{23, 0, 9, 2, 0, 0};

    bus.hostWriteEn = 1'b1; bus.hostWriteAddr = '0; bus.hostDataIn = '0;
    bus.jobValid = 1'b0; bus.jobBase = '0; bus.jobStride = '0; bus.jobLen = '0;
    bus.jobCount = '0; bus.outReady = 1'b0;
    #12;
    chk("reset jobReady", bus.jobReady, 1);
    chk("reset busy", bus.busy, 0);
    chk("reset memRouteEn", bus.memRouteEn, 0);
    chk("reset outValid", bus.outValid, 0);
    chk("reset pulses", {bus.done, bus.jobErr, bus.hostWriteErr}, 0);
    chk("reset outData", bus.outData, 0);
    chk("reset memWriteEn pass-through", bus.memWriteEn, 1);
    bus.hostWriteEn = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < Depth; i++) begin
      @(negedge clk);
      bus.hostWriteEn   = 1'b1;
      bus.hostWriteAddr = AddrWidth'(i);
      bus.hostDataIn    = DataWidth'(i);
      #1;
      if (i == 0 || i == Depth - 1) chk("load memWriteEn", bus.memWriteEn, 1);
    end
    @(negedge clk);
    bus.hostWriteEn = 1'b0;
    chk("no hostWriteErr in IDLE", bus.hostWriteErr, 0);

    for (int i = 0; i < 9; i++) begin
      runJob(vecs[i]);
      if (i == 0) chk("single window vector", lastData, 72'h080706050403020100);
    end

    // Host write while routing is dropped and flagged.
    routerLat = 6;
    sendJob(0, 0, 9, 1);
    waitRoute(ok);
    chk("route seen (busy write)", ok, 1);
    bus.hostWriteEn = 1'b1; bus.hostWriteAddr = AddrWidth'(5); bus.hostDataIn = 8'hAA;
    #1;
    chk("memWriteEn blocked while busy", bus.memWriteEn, 0);
    @(negedge clk);
    bus.hostWriteEn = 1'b0;
    chk("hostWriteErr pulse", bus.hostWriteErr, 1);
    @(negedge clk);
    chk("hostWriteErr clears", bus.hostWriteErr, 0);
    for (int t = 0; t < 50 && !bus.outValid; t++) @(negedge clk);
    chk("outValid (busy write)", bus.outValid, 1);
    chk("buffer untouched by dropped write", bus.outData[47:40], 8'h05);
    bus.outReady = 1'b1;
    @(negedge clk);
    bus.outReady = 1'b0;
    chk("done (busy write)", bus.done, 1);

    // Reset in the middle of ROUTE.
    sendJob(2, 4, 3, 4);
    waitRoute(ok);
    chk("route seen (mid reset)", ok, 1);
    #2 rst = 1'b0;
    #1;
    chk("memRouteEn drops async", bus.memRouteEn, 0);
    chk("busy after reset", bus.busy, 0);
    chk("jobReady after reset", bus.jobReady, 1);
    chk("no pulses after reset", {bus.done, bus.jobErr, bus.outValid}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("memRouteEn held low after release", bus.memRouteEn, 0);
    chk("no done after abandon", bus.done, 0);
    routerLat = 3;
    runJob(vecs[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
